// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - decodes toggle-signalled events into a pending-event queue with valid/ready drain
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               t_in_i,
    input  logic               en_i,
    output logic               pulse_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [CNT_W-1:0]   pending_o,
    output logic [TOTAL_W-1:0] total_o,
    output logic               overflow_o
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   t_prev_q;
    logic                   s_last;
    logic                   edge_det;
    logic                   acc;
    logic                   pop;

    logic                   pulse_q;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic                   overflow_q, overflow_d;

    // Synchronizer chain and level tracker run through reset so that the
    // static level seen at reset release never decodes as an event.
    always_ff @(posedge clk_i) begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], t_in_i};
        t_prev_q <= s_last;
    end

    assign s_last   = sync_q[SYNC_STAGES-1];
    assign edge_det = s_last ^ t_prev_q;
    assign acc      = edge_det & en_i & ~rst_i;
    assign pop      = evt_valid_o & evt_ready_i;

    // Next-state for the pending queue, total count and sticky overflow.
    always_comb begin
        pending_d  = pending_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        if (acc) begin
            total_d = total_q + 1'b1;
        end
        if (acc && !pop) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (pop && !acc) begin
            pending_d = pending_q - 1'b1;
        end
    end

    // Registered event state; reset drops any queued events.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_q    <= 1'b0;
            pending_q  <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pulse_q    <= acc;
            pending_q  <= pending_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign pending_o   = pending_q;
    assign total_o     = total_q;
    assign overflow_o  = overflow_q;
    assign evt_valid_o = (pending_q != '0);

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - randomized self-checking bench for toggle_event_rx
module tb_toggle_event_rx;

    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int TW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          t_in = 1'b0;
    logic          en = 1'b0;
    logic          evt_ready = 1'b0;
    logic          pulse;
    logic          evt_valid;
    logic [CW-1:0] pending;
    logic [TW-1:0] total;
    logic          overflow;

    toggle_event_rx #(.SYNC_STAGES(SYNC), .CNT_W(CW), .TOTAL_W(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .t_in_i      (t_in),
        .en_i        (en),
        .pulse_o     (pulse),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .pending_o   (pending),
        .total_o     (total),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: event decided from sampled t_in history, counters by plain arithmetic.
    bit hist[$];
    int m_pend  = 0;
    int m_total = 0;
    bit m_ovf   = 0;
    bit m_pulse = 0;
    bit cur_t   = 0;

    task automatic cycle(input bit t, input bit e, input bit r, input bit rs);
        bit a;
        bit p;
        int idx;
        t_in = t; en = e; evt_ready = r; rst = rs;
        cur_t = t;
        @(posedge clk);
        hist.push_back(t);
        idx = hist.size() - 1 - SYNC;
        a = 0;
        if (!rs && e && idx >= 1) a = (hist[idx] != hist[idx-1]);
        p = (m_pend != 0) && r;
        if (rs) begin
            m_pend = 0; m_total = 0; m_ovf = 0; m_pulse = 0;
        end else begin
            m_pulse = a;
            if (a) m_total = (m_total + 1) % (1 << TW);
            if (a && !p) begin
                if (m_pend == (1 << CW) - 1) m_ovf = 1;
                else m_pend = m_pend + 1;
            end else if (p && !a) begin
                m_pend = m_pend - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n, input bit t);
        for (int i = 0; i < n; i++) cycle(t, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset(4, 1'b1);
        n_tests++;
        if ({pulse, evt_valid, pending, total, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got p=%b v=%b pend=%0d tot=%0d ovf=%b, want all 0",
                     pulse, evt_valid, pending, total, overflow);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (pulse !== 1'b0 || pending !== '0 || total !== '0) begin
                n_fail++;
                $display("FAIL reset_static[%0d]: got p=%b pend=%0d tot=%0d, want 0 0 0",
                         i, pulse, pending, total);
            end
        end
    endtask

    task automatic test_latency();
        int first;
        do_reset(4, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (pulse === 1'b1 && first < 0) first = i;
        end
        n_tests++;
        if (first != SYNC + 1) begin
            n_fail++;
            $display("FAIL latency: pulse after edge offset %0d, want %0d", first - 1, SYNC);
        end
        n_tests++;
        if (pending !== 4'd1 || total !== 16'd1 || evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_counts: got pend=%0d tot=%0d v=%b, want 1 1 1",
                     pending, total, evt_valid);
        end
    endtask

    task automatic test_overflow();
        int pops;
        do_reset(4, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cycle(~cur_t, 1'b1, 1'b0, 1'b0);
            cycle(cur_t, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(cur_t, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (pending !== 4'd15 || overflow !== 1'b1 || total !== 16'd17) begin
            n_fail++;
            $display("FAIL overflow_fill: got pend=%0d ovf=%b tot=%0d, want 15 1 17",
                     pending, overflow, total);
        end
        pops = 0;
        for (int i = 0; i < 25; i++) begin
            if (evt_valid === 1'b1) pops++;
            cycle(cur_t, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (pending !== m_pend[CW-1:0]) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got pend=%0d, want %0d", i, pending, m_pend);
            end
        end
        n_tests++;
        if (pops != 15 || evt_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_pops: got pops=%0d v=%b ovf=%b, want 15 0 1",
                     pops, evt_valid, overflow);
        end
    endtask

    task automatic test_full_pop_acc();
        do_reset(4, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cycle(~cur_t, 1'b1, 1'b0, 1'b0);
            cycle(cur_t, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(cur_t, 1'b1, 1'b0, 1'b0);
        cycle(~cur_t, 1'b1, 1'b0, 1'b0);
        cycle(cur_t, 1'b1, 1'b0, 1'b0);
        cycle(cur_t, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (pulse !== 1'b1 || pending !== 4'd15 || overflow !== 1'b0 || total !== 16'd16) begin
            n_fail++;
            $display("FAIL full_pop_acc: got p=%b pend=%0d ovf=%b tot=%0d, want 1 15 0 16",
                     pulse, pending, overflow, total);
        end
        cycle(cur_t, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_enable();
        int pulses;
        do_reset(4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(~cur_t, 1'b0, 1'b0, 1'b0);
            cycle(cur_t, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(cur_t, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(cur_t, 1'b1, 1'b0, 1'b0);
            if (pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || pending !== '0 || total !== '0) begin
            n_fail++;
            $display("FAIL enable_no_replay: got pulses=%0d pend=%0d tot=%0d, want 0 0 0",
                     pulses, pending, total);
        end
        cycle(~cur_t, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(cur_t, 1'b1, 1'b0, 1'b0);
            if (pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || pending !== 4'd1 || total !== 16'd1) begin
            n_fail++;
            $display("FAIL enable_one_event: got pulses=%0d pend=%0d tot=%0d, want 1 1 1",
                     pulses, pending, total);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(~cur_t, 1'b1, 1'b0, 1'b0);
            cycle(cur_t, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(cur_t, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (pending !== 4'd5) begin
            n_fail++;
            $display("FAIL mid_reset_fill: got pend=%0d, want 5", pending);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(cur_t, 1'b1, 1'b0, 1'b1);
            n_tests++;
            if ({pulse, evt_valid, pending, total, overflow} !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_clear[%0d]: got p=%b v=%b pend=%0d tot=%0d ovf=%b, want all 0",
                         i, pulse, evt_valid, pending, total, overflow);
            end
        end
        cycle(~cur_t, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(cur_t, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (total !== 16'd1 || pending !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_reset_next: got tot=%0d pend=%0d, want 1 1", total, pending);
        end
    endtask

    task automatic test_random();
        bit t;
        bit e;
        bit r;
        bit rs;
        int rst_left;
        rst_left = 0;
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 2) == 0) ? ~cur_t : cur_t;
            e = ($urandom_range(0, 5) != 0);
            r = ($urandom_range(0, 3) == 0);
            if (rst_left == 0 && $urandom_range(0, 150) == 0) rst_left = SYNC + 1;
            rs = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            cycle(t, e, r, rs);
            n_tests++;
            if (pulse !== m_pulse || evt_valid !== (m_pend != 0) || pending !== m_pend[CW-1:0]
                || total !== m_total[TW-1:0] || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random[%0d]: got p=%b v=%b pend=%0d tot=%0d ovf=%b, want p=%b v=%b pend=%0d tot=%0d ovf=%b",
                         i, pulse, evt_valid, pending, total, overflow,
                         m_pulse, (m_pend != 0), m_pend, m_total, m_ovf);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop_acc();
        test_enable();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
